// File: rtl/imem_loader.sv
// imem_loader: packs a byte stream big-endian into words for instruction memory.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per session.
`ifndef WORD
`define WORD 32
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

module imem_loader #(
    parameter int SIZE = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [$clog2(SIZE):0] word_count,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [`WORD-1:0]      mem_addr,
    output logic [`INSTR_LEN-1:0] mem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);
    localparam int CW = $clog2(SIZE) + 1;
    localparam logic [CW-1:0] MAX_WC = CW'(SIZE);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, CHECK} state_t;
`else
    typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE} state_t;
`endif

    state_t                state_q, state_d;
    logic [CW-1:0]         count_q, words_q;
    logic [1:0]            bcnt_q;
    logic [`WORD-1:0]      addr_q;
    logic [`INSTR_LEN-1:0] word_q;
    logic                  done_q, error_q;
    logic                  start_ok, start_bad, accept, last_word;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            csum_q;
    logic                  csum_bad;
`endif

    assign last_word = (words_q + CW'(1)) == count_q;

    always_comb begin
        state_d    = state_q;
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        cpu_hold   = 1'b0;
        start_ok   = 1'b0;
        start_bad  = 1'b0;
        accept     = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        csum_bad   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (word_count != '0 && word_count <= MAX_WC) begin
                        start_ok = 1'b1;
                        state_d  = RECV;
                    end else begin
                        start_bad = 1'b1;
                    end
                end
            end
            RECV: begin
                byte_ready = 1'b1;
                cpu_hold   = 1'b1;
                if (byte_valid) begin
                    accept = 1'b1;
                    if (bcnt_q == 2'd3) state_d = WRITE;
                end
            end
            WRITE: begin
                mem_we   = 1'b1;
                cpu_hold = 1'b1;
                if (!last_word) state_d = RECV;
`ifdef LOADER_CHECKSUM_EN
                else state_d = CHECK;
`else
                else state_d = DONE;
`endif
            end
            DONE: state_d = IDLE;
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                byte_ready = 1'b1;
                cpu_hold   = 1'b1;
                if (byte_valid) begin
                    if (byte_in == csum_q) begin
                        state_d = DONE;
                    end else begin
                        csum_bad = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            words_q <= '0;
            bcnt_q  <= '0;
            addr_q  <= '0;
            word_q  <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                count_q <= word_count;
                words_q <= '0;
                bcnt_q  <= '0;
                addr_q  <= '0;
                done_q  <= 1'b0;
                error_q <= 1'b0;
            end
            if (start_bad) error_q <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            if (csum_bad) error_q <= 1'b1;
`endif
            if (accept) begin
                bcnt_q <= bcnt_q + 2'd1;
                word_q <= {word_q[`INSTR_LEN-9:0], byte_in};
            end
            if (mem_we) begin
                words_q <= words_q + CW'(1);
                addr_q  <= addr_q + `WORD'(4);
            end
            if (state_d == DONE) done_q <= 1'b1;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running XOR over data bytes only; the checksum byte itself is excluded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum_q <= '0;
        end else if (start_ok) begin
            csum_q <= '0;
        end else if (accept) begin
            csum_q <= csum_q ^ byte_in;
        end
    end
`endif

    assign mem_addr  = addr_q;
    assign mem_wdata = word_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed stimulus, queue-based write model checked every cycle.
// Covers normal, gapped, boundary, bad-start, mid-session reset and checksum cases.
`timescale 1ns/1ps

module tb_imem_loader;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  word_count = '0;
    logic [7:0]  byte_in = '0;
    logic        byte_valid = 1'b0;
    logic        byte_ready, mem_we, cpu_hold, done, error;
    logic [31:0] mem_addr, mem_wdata;

    int n_checks = 0;
    int n_fail = 0;
    logic [63:0] exp_q[$];
    logic [7:0]  stream[$];

    imem_loader #(.SIZE(16)) dut (
        .clk(clk), .reset(reset), .start(start), .word_count(word_count),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endfunction

    // Every write strobe must match the next expected {addr, data}.
    always @(negedge clk) begin
        logic [63:0] e;
        if (reset && mem_we) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %h data %h, required no write",
                         mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", mem_addr, e[63:32]);
                check("write_data", mem_wdata, e[31:0]);
                check("ready_low_in_write", {31'd0, byte_ready}, 32'd0);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int wc);
        start = 1'b1;
        word_count = 5'(wc);
        cyc();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok = 1'b0;
        byte_in = b;
        byte_valid = 1'b1;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = byte_ready;
            cyc();
        end
        byte_valid = 1'b0;
        check("byte_accepted", {31'd0, ok}, 32'd1);
        repeat (gap) cyc();
    endtask

    task automatic model_words(input int wc);
        for (int i = 0; i < wc; i++)
            exp_q.push_back({32'(4 * i), stream[4*i], stream[4*i+1],
                             stream[4*i+2], stream[4*i+3]});
    endtask

    task automatic load(input int wc, input int gap, input logic [7:0] flip);
        logic [7:0] x;
        x = flip;
        do_start(wc);
        check("hold_after_start", {31'd0, cpu_hold}, 32'd1);
        check("error_cleared", {31'd0, error}, 32'd0);
        check("done_cleared", {31'd0, done}, 32'd0);
        for (int i = 0; i < 4 * wc; i++) begin
            x = x ^ stream[i];
            send_byte(stream[i], gap);
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(x, gap);
`endif
    endtask

    task automatic wait_end(input bit want_done);
        bit seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            seen = done || error;
        end
        check("session_end_seen", {31'd0, seen}, 32'd1);
        check("done_flag", {31'd0, done}, {31'd0, want_done});
        check("error_flag", {31'd0, error}, {31'd0, !want_done});
        check("hold_released", {31'd0, cpu_hold}, 32'd0);
        check("writes_left", exp_q.size(), 32'd0);
        cyc();
    endtask

    task automatic check_reset_vals();
        check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
    endtask

    initial begin
        repeat (3) cyc();
        check_reset_vals();
        reset = 1'b1;
        repeat (2) cyc();

        // Three words, no gaps, literal expectations
        stream = '{8'hAB, 8'hCD, 8'hEF, 8'h12, 8'hBC, 8'hDE,
                   8'hF1, 8'h23, 8'hCD, 8'hEF, 8'h12, 8'h34};
        exp_q.push_back({32'd0, 32'hABCDEF12});
        exp_q.push_back({32'd4, 32'hBCDEF123});
        exp_q.push_back({32'd8, 32'hCDEF1234});
        load(3, 0, 8'h00);
        wait_end(1'b1);
        check("last_word_literal", mem_wdata, 32'hCDEF1234);

        // Same stream with valid low every other cycle
        model_words(3);
        load(3, 1, 8'h00);
        wait_end(1'b1);

        // Full-depth load
        stream.delete();
        for (int i = 0; i < 64; i++) stream.push_back(8'(i * 37 + 5));
        model_words(16);
        load(16, 0, 8'h00);
        wait_end(1'b1);
        check("full_depth_last", mem_wdata,
              {stream[60], stream[61], stream[62], stream[63]});

        // Illegal word counts
        do_start(0);
        check("wc0_error", {31'd0, error}, 32'd1);
        check("wc0_done_kept", {31'd0, done}, 32'd1);
        check("wc0_idle_ready", {31'd0, byte_ready}, 32'd0);
        check("wc0_idle_hold", {31'd0, cpu_hold}, 32'd0);
        do_start(17);
        repeat (3) cyc();
        check("wc17_error", {31'd0, error}, 32'd1);
        check("wc17_idle_ready", {31'd0, byte_ready}, 32'd0);

        // Reset after 6 bytes of a 3-word load; start mid-session ignored
        stream = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        exp_q.push_back({32'd0, 32'h11223344});
        do_start(3);
        check("mid_error_cleared", {31'd0, error}, 32'd0);
        send_byte(stream[0], 0);
        send_byte(stream[1], 0);
        do_start(1);
        check("start_ignored_hold", {31'd0, cpu_hold}, 32'd1);
        check("start_ignored_ready", {31'd0, byte_ready}, 32'd1);
        for (int i = 2; i < 6; i++) send_byte(stream[i], 0);
        check("writes_before_reset", exp_q.size(), 32'd0);
        reset = 1'b0;
        #1;
        check_reset_vals();
        cyc();
        reset = 1'b1;
        repeat (5) cyc();
        check("no_write_after_reset", exp_q.size(), 32'd0);
        stream = '{8'h67, 8'h89, 8'hAB, 8'hCD};
        exp_q.push_back({32'd0, 32'h6789ABCD});
        load(1, 0, 8'h00);
        wait_end(1'b1);
        check("reload_literal", mem_wdata, 32'h6789ABCD);

`ifdef LOADER_CHECKSUM_EN
        // Checksum match (0F) then mismatch (0E)
        stream = '{8'h01, 8'h02, 8'h04, 8'h08};
        exp_q.push_back({32'd0, 32'h01020408});
        load(1, 0, 8'h00);
        wait_end(1'b1);
        exp_q.push_back({32'd0, 32'h01020408});
        load(1, 0, 8'h01);
        wait_end(1'b0);
`endif

        repeat (3) cyc();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter SIZE, default 16, meaning instruction-memory depth in words.
REQ-002 SHALL have port clk  input  1  meaning the single system clock, rising-edge active.
REQ-003 SHALL have port reset  input  1  meaning asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  meaning a one-cycle pulse that begins a load session.
REQ-005 SHALL have port word_count  input  $clog2(SIZE)+1  meaning the number of words to load, sampled on start.
REQ-006 SHALL have port byte_in  input  8  meaning the incoming program byte.
REQ-007 SHALL have port byte_valid  input  1  meaning byte_in is valid.
REQ-008 SHALL have port byte_ready  output  1  meaning the loader accepts a byte this cycle.
REQ-009 SHALL have port mem_we  output  1  meaning the instruction-memory write strobe.
REQ-010 SHALL have port mem_addr  output  `WORD  meaning the byte address, always a multiple of 4.
REQ-011 SHALL have port mem_wdata  output  `INSTR_LEN  meaning the assembled instruction.
REQ-012 SHALL have port cpu_hold  output  1  meaning drive the iFetch reset high while loading.
REQ-013 SHALL have port done  output  1  meaning the session finished successfully (sticky).
REQ-014 SHALL have port error  output  1  meaning the session was aborted (sticky).

Function
REQ-015 SHALL implement states IDLE, RECV, WRITE and DONE (plus CHECK when LOADER_CHECKSUM_EN is defined).
REQ-016 In IDLE, start with 1<=word_count<=SIZE SHALL latch word_count, clear done/error, clear the address to 0 and enter RECV on the next edge.
REQ-017 In IDLE, start with word_count==0 or word_count>SIZE SHALL set error and remain in IDLE.
REQ-018 A byte SHALL be accepted only on an edge where byte_valid&&byte_ready; byte_ready SHALL be 1 only in RECV (and CHECK).
REQ-019 Bytes SHALL be packed big-endian: the first byte goes to [31:24] and the fourth byte to [7:0].
REQ-020 Acceptance of the fourth byte SHALL enter WRITE; WRITE SHALL last exactly one cycle with mem_we=1, mem_addr=current address and mem_wdata=the assembled word.
REQ-021 After WRITE, the address SHALL increment by 4; if words written < word_count the block SHALL return to RECV, otherwise go to DONE (or CHECK).
REQ-022 DONE SHALL assert done, deassert cpu_hold and return to IDLE on the next edge; done SHALL stay set until the next accepted start.
REQ-023 cpu_hold SHALL be 1 in RECV, WRITE and CHECK, and 0 otherwise.
REQ-024 start SHALL be ignored outside IDLE.
REQ-025 mem_we SHALL be 0 outside WRITE.
REQ-026 Gaps in byte_valid SHALL stall assembly without loss or duplication.

Reset
REQ-027 reset low SHALL asynchronously force state=IDLE, byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, done=0, error=0 and byte counter=0.
REQ-028 Reset asserted mid-session SHALL discard any partial word; no mem_we pulse SHALL follow reset release until a new start is accepted.

Configuration
REQ-029 With macro LOADER_CHECKSUM_EN defined, after the last WRITE the block SHALL enter CHECK and accept one byte compared against the XOR of all accepted data bytes; a match SHALL go to DONE, and a mismatch SHALL set error, leave done=0 and return to IDLE.
REQ-030 With LOADER_CHECKSUM_EN undefined, CHECK and the XOR register SHALL be absent and the last WRITE SHALL go directly to DONE.

Verification
REQ-031 Scenario: reset; start with word_count=3; stream AB CD EF 12 BC DE F1 23 CD EF 12 34 -> exactly three mem_we pulses: addr 0 data ABCDEF12, addr 4 data BCDEF123, addr 8 data CDEF1234; then done=1 and cpu_hold=0.
REQ-032 Scenario: same stream with byte_valid low every other cycle -> identical writes; byte_ready=0 during each WRITE cycle.
REQ-033 Scenario: start with word_count=0, then with word_count=17 (SIZE=16) -> error=1, no mem_we, state IDLE.
REQ-034 Scenario: reset pulsed low after 6 bytes of a 3-word load -> all outputs at reset values immediately; a new 1-word load of 6789ABCD writes addr 0 only.
REQ-035 Scenario: with LOADER_CHECKSUM_EN defined, a 1-word load of 01 02 04 08 followed by checksum 0F -> done=1; the same load followed by checksum 0E -> error=1 and done=0.
